// File: rtl/fetch_sequencer_if.sv
// Instruction-memory bus between the fetch sequencer and a combinational
// 16-entry instruction memory holding pre-decoded R-type fields.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] memAddr;
    logic [4:0]        memRd;
    logic [4:0]        memRs;
    logic [4:0]        memRt;
    logic [4:0]        memSa;
    logic [5:0]        memFunc;

    // Sequencer side: drives the address, receives the fields.
    modport master (
        output memAddr,
        input  memRd, memRs, memRt, memSa, memFunc
    );

    // Memory side: decodes the address, returns the fields.
    modport slave (
        input  memAddr,
        output memRd, memRs, memRt, memSa, memFunc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, walks the instruction memory and loads the
// IF/ID pipeline register, with start, stall, redirect/flush, halt and a
// saturating count of instructions latched since the last start.
module fetch_sequencer #(
    parameter int ADDR_W    = 4,
    parameter int LAST_ADDR = 15,
    parameter bit WRAP_EN   = 1'b0,
    parameter int CNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   startAddr,
    input  logic                stall,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirectAddr,
    fetch_sequencer_if.master   mem,
    output logic [4:0]          idRd,
    output logic [4:0]          idRs,
    output logic [4:0]          idRt,
    output logic [4:0]          idSa,
    output logic [5:0]          idFunc,
    output logic [ADDR_W-1:0]   idPc,
    output logic                idValid,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    fetchCount
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [ADDR_W-1:0] pc;
    logic              at_last;
    logic              advance;

    assign mem.memAddr = pc;
    assign at_last     = (pc == LAST);
    // An instruction is latched only in FETCH with neither redirect nor stall.
    assign advance     = (state == S_FETCH) && !redirect && !stall;

    // Next-state selection; busy/done are registered decodes of this value.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_FETCH;
            S_FETCH: if (advance && at_last && !WRAP_EN) state_next = S_HALT;
            S_HALT:  if (start) state_next = S_FETCH;
            default: state_next = S_IDLE;
        endcase
    end

    // State register with registered busy/done status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == S_FETCH);
            done  <= (state_next == S_HALT);
        end
    end

    // PC, IF/ID register and fetch counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc         <= '0;
            idRd       <= '0;
            idRs       <= '0;
            idRt       <= '0;
            idSa       <= '0;
            idFunc     <= '0;
            idPc       <= '0;
            idValid    <= 1'b0;
            fetchCount <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    idValid <= 1'b0;
                    if (start) begin
                        pc         <= startAddr;
                        fetchCount <= '0;
                    end
                end
                S_FETCH: begin
                    if (redirect) begin
                        pc      <= redirectAddr;
                        idValid <= 1'b0;
                    end else if (!stall) begin
                        idRd    <= mem.memRd;
                        idRs    <= mem.memRs;
                        idRt    <= mem.memRt;
                        idSa    <= mem.memSa;
                        idFunc  <= mem.memFunc;
                        idPc    <= pc;
                        idValid <= 1'b1;
                        if (fetchCount != '1) begin
                            fetchCount <= fetchCount + CNT_W'(1);
                        end
                        if (!at_last) begin
                            pc <= pc + ADDR_W'(1);
                        end else if (WRAP_EN) begin
                            pc <= '0;
                        end
                    end
                end
                S_HALT: begin
                    if (start) begin
                        pc         <= startAddr;
                        fetchCount <= '0;
                        idValid    <= 1'b0;
                    end else if (!stall) begin
                        idValid <= 1'b0;
                    end
                end
                default: begin
                    idValid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a halting instance and a wrapping instance share
// the control inputs; each is checked every cycle against a behavioural model,
// plus directed spot checks of the documented scenarios.
module tb_fetch_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] startAddr;
    logic       stall;
    logic       redirect;
    logic [3:0] redirectAddr;

    logic [25:0] mem [16];

    logic [4:0] id_rd0, id_rs0, id_rt0, id_sa0, id_rd1, id_rs1, id_rt1, id_sa1;
    logic [5:0] id_func0, id_func1;
    logic [3:0] id_pc0, id_pc1;
    logic       id_valid0, id_valid1, busy0, busy1, done0, done1;
    logic [7:0] count0, count1;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: mode 0 = idle, 1 = fetching, 2 = halted.
    int          m_mode  [2];
    int          m_pc    [2];
    int          m_cnt   [2];
    int          m_idpc  [2];
    logic [25:0] m_id    [2];
    bit          m_valid [2];

    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_W(4)) bus0 ();
    fetch_sequencer_if #(.ADDR_W(4)) bus1 ();

    assign {bus0.memRd, bus0.memRs, bus0.memRt, bus0.memSa, bus0.memFunc} = mem[bus0.memAddr];
    assign {bus1.memRd, bus1.memRs, bus1.memRt, bus1.memSa, bus1.memFunc} = mem[bus1.memAddr];

    fetch_sequencer #(.ADDR_W(4), .LAST_ADDR(15), .WRAP_EN(1'b0), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .startAddr(startAddr),
        .stall(stall), .redirect(redirect), .redirectAddr(redirectAddr),
        .mem(bus0.master),
        .idRd(id_rd0), .idRs(id_rs0), .idRt(id_rt0), .idSa(id_sa0), .idFunc(id_func0),
        .idPc(id_pc0), .idValid(id_valid0), .busy(busy0), .done(done0), .fetchCount(count0)
    );

    fetch_sequencer #(.ADDR_W(4), .LAST_ADDR(15), .WRAP_EN(1'b1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .startAddr(startAddr),
        .stall(stall), .redirect(redirect), .redirectAddr(redirectAddr),
        .mem(bus1.master),
        .idRd(id_rd1), .idRs(id_rs1), .idRt(id_rt1), .idSa(id_sa1), .idFunc(id_func1),
        .idPc(id_pc1), .idValid(id_valid1), .busy(busy1), .done(done1), .fetchCount(count1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the rules of the block to one model instance for one clock edge.
    task automatic model_edge(input int w, input bit wrap);
        if (!rst_n) begin
            m_mode[w] = 0; m_pc[w] = 0; m_cnt[w] = 0;
            m_idpc[w] = 0; m_id[w] = '0; m_valid[w] = 0;
        end else if (m_mode[w] == 0) begin
            if (start) begin
                m_pc[w] = int'(startAddr); m_cnt[w] = 0; m_mode[w] = 1;
            end
        end else if (m_mode[w] == 1) begin
            if (redirect) begin
                m_pc[w] = int'(redirectAddr); m_valid[w] = 0;
            end else if (!stall) begin
                m_id[w]    = mem[m_pc[w]];
                m_idpc[w]  = m_pc[w];
                m_valid[w] = 1;
                m_cnt[w]   = (m_cnt[w] >= 255) ? 255 : m_cnt[w] + 1;
                if (m_pc[w] < 15)  m_pc[w] = m_pc[w] + 1;
                else if (wrap)     m_pc[w] = 0;
                else               m_mode[w] = 2;
            end
        end else begin
            if (start) begin
                m_pc[w] = int'(startAddr); m_cnt[w] = 0; m_valid[w] = 0; m_mode[w] = 1;
            end else if (!stall) begin
                m_valid[w] = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/w0 memAddr"}, bus0.memAddr, m_pc[0]);
        chk({tag, "/w0 idFields"}, {id_rd0, id_rs0, id_rt0, id_sa0, id_func0}, m_id[0]);
        chk({tag, "/w0 idPc"}, id_pc0, m_idpc[0]);
        chk({tag, "/w0 idValid"}, id_valid0, m_valid[0]);
        chk({tag, "/w0 busy"}, busy0, m_mode[0] == 1);
        chk({tag, "/w0 done"}, done0, m_mode[0] == 2);
        chk({tag, "/w0 fetchCount"}, count0, m_cnt[0]);
        chk({tag, "/w1 memAddr"}, bus1.memAddr, m_pc[1]);
        chk({tag, "/w1 idFields"}, {id_rd1, id_rs1, id_rt1, id_sa1, id_func1}, m_id[1]);
        chk({tag, "/w1 idPc"}, id_pc1, m_idpc[1]);
        chk({tag, "/w1 idValid"}, id_valid1, m_valid[1]);
        chk({tag, "/w1 busy"}, busy1, m_mode[1] == 1);
        chk({tag, "/w1 done"}, done1, m_mode[1] == 2);
        chk({tag, "/w1 fetchCount"}, count1, m_cnt[1]);
    endtask

    // One clock: inputs already applied, model follows the edge, check at negedge.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge(0, 1'b0);
        model_edge(1, 1'b1);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; startAddr = '0;
        stall = 1'b0; redirect = 1'b0; redirectAddr = '0;
        for (int i = 0; i < 16; i++) mem[i] = 26'($urandom);
        mem[0] = {5'd1, 5'd3, 5'd2, 5'd0, 6'h22};
        mem[1] = {5'd2, 5'd5, 5'd12, 5'd0, 6'h24};
        mem[2] = {5'd0, 5'd0, 5'd0, 5'd0, 6'd6};

        step("reset");
        step("reset");
        chk("reset busy", busy0, 1'b0);
        chk("reset done", done0, 1'b0);

        // Idle ignores stall and redirect.
        rst_n = 1'b1; stall = 1'b1; redirect = 1'b1; redirectAddr = 4'd5;
        step("idle");
        stall = 1'b0; redirect = 1'b0;

        start = 1'b1; startAddr = 4'd0;
        step("start");
        start = 1'b0;
        step("first");
        chk("first idRd", id_rd0, 5'd1);
        chk("first idRs", id_rs0, 5'd3);
        chk("first idRt", id_rt0, 5'd2);
        chk("first idFunc", id_func0, 6'h22);
        chk("first idPc", id_pc0, 4'd0);
        chk("first idValid", id_valid0, 1'b1);
        chk("first memAddr", bus0.memAddr, 4'd1);
        chk("first fetchCount", count0, 8'd1);
        step("second");
        chk("second idRt", id_rt0, 5'd12);
        chk("second idFunc", id_func0, 6'h24);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("stall");
            chk("stall memAddr", bus0.memAddr, 4'd2);
            chk("stall fetchCount", count0, 8'd2);
        end
        stall = 1'b0;
        step("release");
        chk("release idFunc", id_func0, 6'd6);
        chk("release idPc", id_pc0, 4'd2);
        step("to4");

        redirect = 1'b1; stall = 1'b1; redirectAddr = 4'd9;
        step("redirect");
        chk("redirect memAddr", bus0.memAddr, 4'd9);
        chk("redirect idValid", id_valid0, 1'b0);
        redirect = 1'b0; stall = 1'b0;
        step("after redirect");
        chk("after redirect idPc", id_pc0, 4'd9);
        chk("after redirect idValid", id_valid0, 1'b1);

        // Synchronous reset mid-fetch at pc=7 with stall and redirect.
        redirect = 1'b1; redirectAddr = 4'd7;
        step("to7");
        rst_n = 1'b0; stall = 1'b1; redirect = 1'b1;
        #2;
        check_all("no edge");
        chk("no edge memAddr", bus0.memAddr, 4'd7);
        step("midreset");
        chk("midreset memAddr", bus0.memAddr, 4'd0);
        chk("midreset busy", busy0, 1'b0);
        rst_n = 1'b1; stall = 1'b0; redirect = 1'b0;

        // Halt boundary vs. wrap.
        start = 1'b1; startAddr = 4'd14;
        step("start14");
        start = 1'b0;
        step("at14");
        chk("at14 idPc", id_pc0, 4'd14);
        step("at15");
        chk("at15 idPc", id_pc0, 4'd15);
        chk("at15 done", done0, 1'b1);
        chk("at15 busy", busy0, 1'b0);
        chk("at15 fetchCount", count0, 8'd2);
        chk("wrap memAddr", bus1.memAddr, 4'd0);
        chk("wrap busy", busy1, 1'b1);
        step("halt drop");
        chk("halt idValid", id_valid0, 1'b0);
        start = 1'b1; startAddr = 4'd3;
        step("restart");
        chk("restart memAddr", bus0.memAddr, 4'd3);
        start = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rst_n        = ($urandom_range(0, 99) != 0);
            start        = ($urandom_range(0, 19) == 0);
            startAddr    = 4'($urandom);
            stall        = ($urandom_range(0, 3) == 0);
            redirect     = ($urandom_range(0, 9) == 0);
            redirectAddr = 4'($urandom);
            step("random");
        end

        // Counter saturation on the wrapping instance.
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; redirect = 1'b0;
        step("sat reset");
        rst_n = 1'b1; start = 1'b1; startAddr = 4'd0;
        step("sat start");
        start = 1'b0;
        for (int i = 0; i < 300; i++) step("sat");
        chk("sat fetchCount", count1, 8'd255);
        chk("sat busy", busy1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
